// File: rtl/scarv_sim_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// scarv_sim_ctrl_pkg
// Shared types and defaults for the simulation-control monitor.
//   state_e        : monitor state as seen on state_o (RUN, DRAIN, DONE)
//   stop_reason_e  : why the run ended, as seen on stop_reason_o
//   DEF_*          : default signalling addresses and drain length
//   drain_width()  : bit width of the drain down-counter
// -----------------------------------------------------------------------------
package scarv_sim_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        RSN_NONE   = 2'd0,
        RSN_STOP   = 2'd1,
        RSN_TRAP   = 2'd2,
        RSN_SIMLEN = 2'd3
    } stop_reason_e;

    localparam int unsigned DEF_STOP_ADDR    = 0;
    localparam int unsigned DEF_TRAP_ADDR    = 8;
    localparam int unsigned DEF_DRAIN_CYCLES = 50;

    // A drain of length 0 still needs a one-bit register.
    function automatic int drain_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/scarv_sim_ctrl_sat_cnt.sv
// -----------------------------------------------------------------------------
// scarv_sim_ctrl_sat_cnt
// Saturating up-counter: holds at all-ones instead of wrapping.
//   clk   : clock
//   rst   : asynchronous active-high reset, clears the count
//   inc   : increment request for this cycle
//   clr   : synchronous clear (wins over inc)
//   count : current count value
// -----------------------------------------------------------------------------
module scarv_sim_ctrl_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/scarv_sim_ctrl.sv
// -----------------------------------------------------------------------------
// scarv_sim_ctrl
// Simulation-control monitor. Snoops data-memory writes for the stop and trap
// signalling addresses, counts cycles / retired instructions / traps, runs a
// fixed drain window after a stop event and raises a sticky done_o.
//
// Configuration macro: SCARV_SIM_CTRL_TRAP_STOP_EN
//   defined   : a trap write in RUN starts the drain with reason TRAP
//   undefined : trap writes are only counted
//
// Ports:
//   clk_i, rst_i       : clock, asynchronous active-high reset
//   data_mem_req_i     : data-memory request
//   data_mem_we_i      : write enable
//   data_mem_addr_i    : word address
//   data_mem_wdata_i   : write data (captured as exit code)
//   trs_valid_i        : instruction retired this cycle
//   simlen_i           : cycle limit, 0 = unlimited
//   state_o            : RUN / DRAIN / DONE
//   stop_reason_o      : NONE / STOP / TRAP / SIMLEN
//   exit_code_o        : wdata captured at the ending write
//   cycles_o           : elapsed cycles
//   retired_o          : retired instructions
//   trap_count_o       : trap writes seen
//   done_o             : sticky end-of-test flag
// -----------------------------------------------------------------------------
module scarv_sim_ctrl
    import scarv_sim_ctrl_pkg::*;
#(
    parameter int          AddrW       = 15,
    parameter int unsigned StopAddr    = DEF_STOP_ADDR,
    parameter int unsigned TrapAddr    = DEF_TRAP_ADDR,
    parameter int unsigned DrainCycles = DEF_DRAIN_CYCLES,
    parameter int          CntW        = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             data_mem_req_i,
    input  logic             data_mem_we_i,
    input  logic [AddrW-1:0] data_mem_addr_i,
    input  logic [31:0]      data_mem_wdata_i,
    input  logic             trs_valid_i,
    input  logic [CntW-1:0]  simlen_i,
    output logic [1:0]       state_o,
    output logic [1:0]       stop_reason_o,
    output logic [31:0]      exit_code_o,
    output logic [CntW-1:0]  cycles_o,
    output logic [CntW-1:0]  retired_o,
    output logic [7:0]       trap_count_o,
    output logic             done_o
);

    localparam int             DW         = drain_width(DrainCycles);
    localparam logic [DW-1:0]  DRAIN_LOAD = DW'(DrainCycles);

    state_e        state_q, state_d;
    stop_reason_e  reason_q, reason_d;
    logic [31:0]   exit_q, exit_d;
    logic [DW-1:0] drain_q, drain_d;
    logic          done_q;

    logic          wr_ev;
    logic          stop_ev;
    logic          trap_ev;
    logic          end_ev;
    stop_reason_e  ev_reason;
    logic          simlen_hit;
    logic          active;

    assign wr_ev   = data_mem_req_i & data_mem_we_i;
    assign stop_ev = wr_ev & (data_mem_addr_i == AddrW'(StopAddr));
    assign trap_ev = wr_ev & (data_mem_addr_i == AddrW'(TrapAddr));

`ifdef SCARV_SIM_CTRL_TRAP_STOP_EN
    assign end_ev  = stop_ev | trap_ev;
`else
    assign end_ev  = stop_ev;
`endif

    assign ev_reason = stop_ev ? RSN_STOP : RSN_TRAP;

    // The limit is reached on the edge that takes cycles_o up to simlen_i.
    assign simlen_hit = (simlen_i != '0) && (cycles_o == (simlen_i - CntW'(1)));
    assign active     = (state_q != ST_DONE);

    // Next-state logic. A stop/trap event that lands on the simlen edge still
    // owns the reason and exit code, but the drain is skipped.
    always_comb begin
        state_d  = state_q;
        reason_d = reason_q;
        exit_d   = exit_q;
        drain_d  = drain_q;
        case (state_q)
            ST_RUN: begin
                if (end_ev) begin
                    reason_d = ev_reason;
                    exit_d   = data_mem_wdata_i;
                    drain_d  = DRAIN_LOAD;
                    state_d  = simlen_hit ? ST_DONE : ST_DRAIN;
                end else if (simlen_hit) begin
                    reason_d = RSN_SIMLEN;
                    state_d  = ST_DONE;
                end
            end
            ST_DRAIN: begin
                if (simlen_hit || (drain_q == '0)) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_DONE;
            end
        endcase
    end

    // State, capture registers and the registered done flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_RUN;
            reason_q <= RSN_NONE;
            exit_q   <= '0;
            drain_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            reason_q <= reason_d;
            exit_q   <= exit_d;
            drain_q  <= drain_d;
            done_q   <= (state_d == ST_DONE);
        end
    end

    scarv_sim_ctrl_sat_cnt #(.W(CntW)) u_cycles (
        .clk   (clk_i),
        .rst   (rst_i),
        .inc   (active),
        .clr   (1'b0),
        .count (cycles_o)
    );

    scarv_sim_ctrl_sat_cnt #(.W(CntW)) u_retired (
        .clk   (clk_i),
        .rst   (rst_i),
        .inc   (active & trs_valid_i),
        .clr   (1'b0),
        .count (retired_o)
    );

    scarv_sim_ctrl_sat_cnt #(.W(8)) u_traps (
        .clk   (clk_i),
        .rst   (rst_i),
        .inc   (active & trap_ev),
        .clr   (1'b0),
        .count (trap_count_o)
    );

    assign state_o       = state_q;
    assign stop_reason_o = reason_q;
    assign exit_code_o   = exit_q;
    assign done_o        = done_q;

endmodule

// File: tb/tb_scarv_sim_ctrl.sv
// -----------------------------------------------------------------------------
// tb_scarv_sim_ctrl
// Directed bench for scarv_sim_ctrl with default parameters. Expected values
// are queued when stimulus is driven and popped when the output is sampled.
// -----------------------------------------------------------------------------
module tb_scarv_sim_ctrl;

    localparam int AddrW = 15;
    localparam int CntW  = 32;
    localparam logic [AddrW-1:0] STOP_A = 15'd0;
    localparam logic [AddrW-1:0] TRAP_A = 15'd8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req = 1'b0;
    logic             we  = 1'b0;
    logic [AddrW-1:0] addr = '0;
    logic [31:0]      wdata = '0;
    logic             trs = 1'b0;
    logic [CntW-1:0]  simlen = '0;

    logic [1:0]       state_o;
    logic [1:0]       stop_reason_o;
    logic [31:0]      exit_code_o;
    logic [CntW-1:0]  cycles_o;
    logic [CntW-1:0]  retired_o;
    logic [7:0]       trap_count_o;
    logic             done_o;

    int total = 0;
    int bad   = 0;
    int edges;

    typedef struct {
        string       tag;
        logic [31:0] value;
    } exp_t;

    exp_t expQ[$];

    scarv_sim_ctrl dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .data_mem_req_i   (req),
        .data_mem_we_i    (we),
        .data_mem_addr_i  (addr),
        .data_mem_wdata_i (wdata),
        .trs_valid_i      (trs),
        .simlen_i         (simlen),
        .state_o          (state_o),
        .stop_reason_o    (stop_reason_o),
        .exit_code_o      (exit_code_o),
        .cycles_o         (cycles_o),
        .retired_o        (retired_o),
        .trap_count_o     (trap_count_o),
        .done_o           (done_o)
    );

    always #5 clk = ~clk;

    task automatic pushExp(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag   = tag;
        e.value = v;
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input logic [31:0] obs);
        exp_t e;
        total++;
        if (expQ.size() == 0) begin
            bad++;
            $error("[TB] FAIL scoreboard_empty observed=%0h expected=none", obs);
        end else begin
            e = expQ.pop_front();
            assert (obs === e.value) else begin
                bad++;
                $error("[TB] FAIL %s observed=%0h expected=%0h", e.tag, obs, e.value);
            end
        end
    endtask

    task automatic applyStimulus(input logic r, input logic w,
                                 input logic [AddrW-1:0] a,
                                 input logic [31:0] d, input logic t);
        req   = r;
        we    = w;
        addr  = a;
        wdata = d;
        trs   = t;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic memWrite(input logic [AddrW-1:0] a, input logic [31:0] d);
        applyStimulus(1'b1, 1'b1, a, d, 1'b0);
        step(1);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic doReset(input logic [CntW-1:0] sl);
        simlen = sl;
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    task automatic waitDone(input int limit, output int n);
        n = 0;
        while (!done_o && n < limit) begin
            step(1);
            n++;
        end
    endtask

    initial begin
        // Reset values
        doReset('0);
        pushExp("rst_state", 0);  checkOutput(32'(state_o));
        pushExp("rst_reason", 0); checkOutput(32'(stop_reason_o));
        pushExp("rst_exit", 0);   checkOutput(exit_code_o);
        pushExp("rst_cycles", 0); checkOutput(cycles_o);
        pushExp("rst_retired", 0); checkOutput(retired_o);
        pushExp("rst_traps", 0);  checkOutput(32'(trap_count_o));
        pushExp("rst_done", 0);   checkOutput(32'(done_o));

        // Retired counting: 40 of 60 cycles
        doReset('0);
        pushExp("retired_40", 40);
        pushExp("cycles_60", 60);
        for (int i = 0; i < 60; i++) begin
            trs = (i % 3 != 2);
            step(1);
        end
        trs = 1'b0;
        checkOutput(retired_o);
        checkOutput(cycles_o);

        // Stop write at edge 100, second stop during drain, writes in DONE
        doReset('0);
        step(99);
        pushExp("stop_state", 1);
        pushExp("stop_reason", 1);
        pushExp("stop_exit", 32'h2A);
        pushExp("stop_cycles", 100);
        memWrite(STOP_A, 32'h2A);
        checkOutput(32'(state_o));
        checkOutput(32'(stop_reason_o));
        checkOutput(exit_code_o);
        checkOutput(cycles_o);
        step(10);
        pushExp("drain_exit_kept", 32'h2A);
        memWrite(STOP_A, 32'h55);
        checkOutput(exit_code_o);
        step(39);
        pushExp("drain_not_done", 0);
        pushExp("drain_state", 1);
        checkOutput(32'(done_o));
        checkOutput(32'(state_o));
        step(1);
        pushExp("stop_done", 1);
        pushExp("stop_done_state", 2);
        pushExp("stop_done_cycles", 151);
        checkOutput(32'(done_o));
        checkOutput(32'(state_o));
        checkOutput(cycles_o);
        pushExp("frozen_cycles", 151);
        pushExp("frozen_exit", 32'h2A);
        pushExp("frozen_done", 1);
        memWrite(STOP_A, 32'h77);
        step(4);
        checkOutput(cycles_o);
        checkOutput(exit_code_o);
        checkOutput(32'(done_o));

        // Reset pulse mid-drain, then a new stop is honoured
        doReset('0);
        step(9);
        memWrite(STOP_A, 32'h11);
        step(5);
        rst = 1'b1;
        #1;
        pushExp("midrst_state", 0);
        pushExp("midrst_reason", 0);
        pushExp("midrst_exit", 0);
        pushExp("midrst_cycles", 0);
        pushExp("midrst_done", 0);
        checkOutput(32'(state_o));
        checkOutput(32'(stop_reason_o));
        checkOutput(exit_code_o);
        checkOutput(cycles_o);
        checkOutput(32'(done_o));
        step(1);
        rst = 1'b0;
        step(4);
        pushExp("restop_state", 1);
        pushExp("restop_exit", 32'h33);
        memWrite(STOP_A, 32'h33);
        checkOutput(32'(state_o));
        checkOutput(exit_code_o);
        pushExp("restop_drain_edges", 51);
        pushExp("restop_cycles", 56);
        waitDone(100, edges);
        checkOutput(32'(edges));
        checkOutput(cycles_o);

        // Trap write at edge 20
        doReset('0);
        step(19);
`ifdef SCARV_SIM_CTRL_TRAP_STOP_EN
        pushExp("trap_count", 1);
        pushExp("trap_state", 1);
        pushExp("trap_reason", 2);
        pushExp("trap_exit", 32'h5);
        memWrite(TRAP_A, 32'h5);
        checkOutput(32'(trap_count_o));
        checkOutput(32'(state_o));
        checkOutput(32'(stop_reason_o));
        checkOutput(exit_code_o);
        pushExp("trap_done_cycles", 71);
        waitDone(100, edges);
        checkOutput(cycles_o);
`else
        pushExp("trap_count", 1);
        pushExp("trap_state_run", 0);
        pushExp("trap_reason_none", 0);
        memWrite(TRAP_A, 32'h5);
        checkOutput(32'(trap_count_o));
        checkOutput(32'(state_o));
        checkOutput(32'(stop_reason_o));
        step(9);
        pushExp("trap_then_stop_reason", 1);
        pushExp("trap_then_stop_exit", 32'h7);
        pushExp("trap_then_stop_cycles", 81);
        memWrite(STOP_A, 32'h7);
        waitDone(100, edges);
        checkOutput(32'(stop_reason_o));
        checkOutput(exit_code_o);
        checkOutput(cycles_o);
`endif

        // Simlen = 30 with no writes
        doReset(32'd30);
        step(29);
        pushExp("simlen_pre_done", 0);
        pushExp("simlen_pre_cycles", 29);
        checkOutput(32'(done_o));
        checkOutput(cycles_o);
        step(1);
        pushExp("simlen_done", 1);
        pushExp("simlen_reason", 3);
        pushExp("simlen_cycles", 30);
        pushExp("simlen_state", 2);
        checkOutput(32'(done_o));
        checkOutput(32'(stop_reason_o));
        checkOutput(cycles_o);
        checkOutput(32'(state_o));
        step(3);
        pushExp("simlen_frozen", 30);
        checkOutput(cycles_o);

        // Stop write on the simlen edge
        doReset(32'd30);
        step(29);
        pushExp("simstop_done", 1);
        pushExp("simstop_reason", 1);
        pushExp("simstop_exit", 32'h99);
        pushExp("simstop_cycles", 30);
        memWrite(STOP_A, 32'h99);
        checkOutput(32'(done_o));
        checkOutput(32'(stop_reason_o));
        checkOutput(exit_code_o);
        checkOutput(cycles_o);

        // Simlen reached during drain keeps reason STOP
        doReset(32'd60);
        step(19);
        memWrite(STOP_A, 32'h44);
        step(39);
        pushExp("drainsim_pre_done", 0);
        checkOutput(32'(done_o));
        step(1);
        pushExp("drainsim_done", 1);
        pushExp("drainsim_reason", 1);
        pushExp("drainsim_cycles", 60);
        checkOutput(32'(done_o));
        checkOutput(32'(stop_reason_o));
        checkOutput(cycles_o);

        // Unlimited run, no writes
        doReset('0);
        pushExp("unlim_done", 0);
        pushExp("unlim_cycles", 10000);
        pushExp("unlim_state", 0);
        step(10000);
        checkOutput(32'(done_o));
        checkOutput(cycles_o);
        checkOutput(32'(state_o));

        // 300 back-to-back trap writes
        doReset('0);
`ifdef SCARV_SIM_CTRL_TRAP_STOP_EN
        pushExp("trap_sat", 52);
`else
        pushExp("trap_sat", 255);
`endif
        applyStimulus(1'b1, 1'b1, TRAP_A, 32'h1, 1'b0);
        step(300);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
        checkOutput(32'(trap_count_o));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
